sumador_serie_4bits: RTL

- Bit-serial adder. It is the additive counterpart of the team's combinational 4-bit subtractor.
- Accepts two ANCHO-bit operands on a start pulse and adds them LSB-first, one bit per clock, through a single carry flip-flop.
- Returns the sum and carry-out with a one-cycle done pulse.
- Sits in the arithmetic datapath wherever area matters more than latency, and shares operand conventions with the subtractor (X, Y, result R).

---
 rtl/sumador_serie_4bits_pkg.sv | 14 +
 rtl/sumador_serie_4bits_celda.sv | 18 +
 rtl/sumador_serie_4bits.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sumador_serie_4bits_pkg.sv
// Shared definitions for the bit-serial adder family.
//   - estado_t  : control states of the serial adder (REPOSO, SUMANDO, FIN)
//   - ANCHO_DEF : default operand/result width
package sumador_defs;

    localparam int ANCHO_DEF = 4;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        SUMANDO = 2'd1,
        FIN     = 2'd2
    } estado_t;

endpackage : sumador_defs

// File: rtl/sumador_serie_4bits_celda.sv
// One-bit full adder cell, reusable by serial and ripple adder/subtractors.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
module celda_sumador_completo (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : celda_sumador_completo

// File: rtl/sumador_serie_4bits.sv
// Bit-serial adder: captures X and Y on an accepted start, adds them LSB
// first through one full-adder cell and a carry flip-flop, then publishes
// R = (X+Y) mod 2^ANCHO and CarriSalida with a one-cycle listo pulse.
// Optional macro SUMADOR_RESTA_EN adds input modo; modo=1 computes X-Y and
// CarriSalida then reports borrow (1 when X<Y).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   inicio       : start request, only honoured in REPOSO
//   X, Y         : operands (ANCHO bits), captured on acceptance
//   modo         : (SUMADOR_RESTA_EN only) 0 = add, 1 = subtract
//   ocupado      : high from the cycle after acceptance until listo drops
//   listo        : one-cycle done pulse
//   R            : result, held until the next completion
//   CarriSalida  : carry-out (or borrow in subtract mode), held with R
module sumador_serie_4bits
    import sumador_defs::*;
#(
    parameter int ANCHO = ANCHO_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inicio,
    input  logic [ANCHO-1:0] X,
    input  logic [ANCHO-1:0] Y,
`ifdef SUMADOR_RESTA_EN
    input  logic             modo,
`endif
    output logic             ocupado,
    output logic             listo,
    output logic [ANCHO-1:0] R,
    output logic             CarriSalida
);

    localparam int CW = $clog2(ANCHO) + 1;

    estado_t          estado_r;
    estado_t          estado_sig_s;
    logic [ANCHO-1:0] sh_x_r;
    logic [ANCHO-1:0] sh_y_r;
    logic [ANCHO-1:0] sh_res_r;
    logic [ANCHO-1:0] res_sig_s;
    logic [ANCHO-1:0] r_r;
    logic [CW-1:0]    cuenta_r;
    logic             carry_r;
    logic             carri_salida_r;
    logic             ocupado_r;
    logic             listo_r;
    logic             suma_bit_s;
    logic             cout_s;
    logic             ultimo_s;
    logic             modo_ent_s;

`ifdef SUMADOR_RESTA_EN
    logic modo_r;

    assign modo_ent_s = modo;

    // Subtract mode is latched with the operands so later changes on modo are harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modo_r <= 1'b0;
        end else if (estado_r == REPOSO && inicio) begin
            modo_r <= modo;
        end else begin
            modo_r <= modo_r;
        end
    end
`else
    localparam logic modo_r = 1'b0;

    assign modo_ent_s = 1'b0;
`endif

    celda_sumador_completo u_celda (
        .a    (sh_x_r[0]),
        .b    (sh_y_r[0]),
        .cin  (carry_r),
        .s    (suma_bit_s),
        .cout (cout_s)
    );

    assign ultimo_s = (cuenta_r == CW'(ANCHO - 1));
    // New sum bit enters at the MSB; after ANCHO shifts the first bit sits at the LSB.
    assign res_sig_s = (sh_res_r >> 1'b1) | {suma_bit_s, {(ANCHO-1){1'b0}}};

    // Next-state logic of the control FSM.
    always_comb begin
        estado_sig_s = estado_r;
        case (estado_r)
            REPOSO: begin
                if (inicio) begin
                    estado_sig_s = SUMANDO;
                end else begin
                    estado_sig_s = REPOSO;
                end
            end
            SUMANDO: begin
                if (ultimo_s) begin
                    estado_sig_s = FIN;
                end else begin
                    estado_sig_s = SUMANDO;
                end
            end
            FIN:     estado_sig_s = REPOSO;
            default: estado_sig_s = REPOSO;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r <= REPOSO;
        end else begin
            estado_r <= estado_sig_s;
        end
    end

    // Serial datapath: operand shifters, carry FF, bit counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_x_r         <= '0;
            sh_y_r         <= '0;
            sh_res_r       <= '0;
            r_r            <= '0;
            cuenta_r       <= '0;
            carry_r        <= 1'b0;
            carri_salida_r <= 1'b0;
        end else begin
            case (estado_r)
                REPOSO: begin
                    if (inicio) begin
                        // Subtraction is X + ~Y with carry-in 1.
                        sh_x_r   <= X;
                        sh_y_r   <= modo_ent_s ? ~Y : Y;
                        carry_r  <= modo_ent_s;
                        cuenta_r <= '0;
                        sh_res_r <= '0;
                    end else begin
                        sh_x_r <= sh_x_r;
                    end
                end
                SUMANDO: begin
                    sh_x_r   <= sh_x_r >> 1'b1;
                    sh_y_r   <= sh_y_r >> 1'b1;
                    sh_res_r <= res_sig_s;
                    carry_r  <= cout_s;
                    cuenta_r <= cuenta_r + CW'(1);
                    if (ultimo_s) begin
                        r_r            <= res_sig_s;
                        // In subtract mode a missing carry means a borrow.
                        carri_salida_r <= cout_s ^ modo_r;
                    end else begin
                        r_r <= r_r;
                    end
                end
                default: begin
                    sh_x_r <= sh_x_r;
                end
            endcase
        end
    end

    // Status outputs: listo follows FIN by one edge, ocupado covers the listo cycle too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ocupado_r <= 1'b0;
            listo_r   <= 1'b0;
        end else begin
            ocupado_r <= (estado_sig_s != REPOSO) || (estado_r == FIN);
            listo_r   <= (estado_r == FIN);
        end
    end

    assign ocupado     = ocupado_r;
    assign listo       = listo_r;
    assign R           = r_r;
    assign CarriSalida = carri_salida_r;

endmodule : sumador_serie_4bits
